// File: rtl/apb_master_fsm.sv
// apb_master_fsm: single-word request port to APB3 SETUP/ACCESS master with inactivity timeout
module apb_master_fsm #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic hs, done, abort;
  always_comb begin
    hs = state == IDLE && req_valid;
    done = state == ACCESS && PREADY;
    abort = TIMEOUT_CYCLES != 0 && state == ACCESS && !PREADY && cnt == CW'(TIMEOUT_CYCLES - 1);
    cnt_n = state == SETUP ? '0 : (state == ACCESS && !PREADY && cnt != '1) ? cnt + CW'(1) : cnt;
    state_n = hs ? SETUP : state == SETUP ? ACCESS : (done || abort) ? IDLE : state;
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
      cnt <= '0;
      req_ready <= 1'b1;
      busy <= 1'b0;
      PSEL <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE <= 1'b0;
      PADDR <= '0;
      PWDATA <= '0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      req_ready <= state_n == IDLE;
      busy <= state_n != IDLE;
      PSEL <= state_n != IDLE;
      PENABLE <= state_n == ACCESS;
      if (hs) begin
        PADDR <= req_addr;
        PWRITE <= req_write;
        PWDATA <= req_wdata;
      end
      rsp_valid <= done || abort;
      rsp_err <= done ? PSLVERR : abort;
      rsp_timeout <= abort;
      rsp_rdata <= (done && !PWRITE) ? PRDATA : '0;
    end
  end
endmodule
